// File: rtl/mem_stage_seq.sv
// MEM stage with a synchronous-read data memory sitting between the EX/MEM
// and MEM/WB pipeline registers. Handles byte/half/word stores with byte
// enables, sign/zero-extended loads, misalignment flagging, stall/flush from
// the hazard unit and a 1- or 2-cycle RAM read latency. With a 2-cycle read
// a load spends one extra cycle in WAIT while mem_busy holds the pipeline.
module mem_stage_seq #(
   parameter int WIDTH    = 32,
   parameter int SIZE     = 256,
   parameter int READ_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_in,
   input  logic             flush_in,
   input  logic [WIDTH-1:0] ALU_out_EXMEM,
   input  logic [WIDTH-1:0] rs2_data_EXMEM,
   input  logic [2:0]       funct3_EXMEM,
   input  logic             mem_rd_en_EXMEM,
   input  logic             mem_wr_en_EXMEM,
   input  logic             reg_wr_en_EXMEM,
   input  logic [1:0]       reg_wr_ctrl_EXMEM,
   input  logic [4:0]       rd_EXMEM,
   input  logic [WIDTH-1:0] pc_4_EXMEM,
   output logic [WIDTH-1:0] ALU_out_MEMWB,
   output logic [WIDTH-1:0] pc_4_MEMWB,
   output logic [WIDTH-1:0] mem_rd_data_MEMWB,
   output logic [1:0]       reg_wr_ctrl_MEMWB,
   output logic [4:0]       rd_MEMWB,
   output logic             reg_wr_en_MEMWB,
   output logic             misaligned_MEMWB,
   output logic             mem_busy
);

   localparam int LOGSIZE = $clog2(SIZE);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Select and extend the addressed byte/half of a little-endian word.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'd0;
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b010:  r = word;
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   state_t state_q, state_d;

   logic [LOGSIZE-1:0] word_idx_s;
   logic [1:0]         off_s;
   logic               is_load_s;
   logic               mis_s;
   logic [3:0]         be_s;
   logic [WIDTH-1:0]   wdata_s;
   logic               busy_s, capture_s, bubble_s, we_s;

   logic [WIDTH-1:0] mem_q [SIZE];
   logic [WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;

   logic [WIDTH-1:0] alu_q, alu_d, pc4_q, pc4_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic [4:0]       rd_q, rd_d;
   logic             rwe_q, rwe_d, mis_q, mis_d, isld_q, isld_d;
   logic [1:0]       off_q, off_d;
   logic [2:0]       f3_q, f3_d;

   assign word_idx_s = ALU_out_EXMEM[LOGSIZE+1:2];
   assign off_s      = ALU_out_EXMEM[1:0];
   // A store wins when both enables are raised.
   assign is_load_s  = mem_rd_en_EXMEM & ~mem_wr_en_EXMEM;

   // Misalignment: halves need an even address, words a 4-byte aligned one.
   always_comb begin
      mis_s = 1'b0;
      if (mem_rd_en_EXMEM || mem_wr_en_EXMEM) begin
         case (funct3_EXMEM)
            3'b001, 3'b101: mis_s = off_s[0];
            3'b010:         mis_s = |off_s;
            default:        mis_s = 1'b0;
         endcase
      end else begin
         mis_s = 1'b0;
      end
   end

   // Store byte enables and lane-replicated write data.
   always_comb begin
      be_s    = 4'b0000;
      wdata_s = rs2_data_EXMEM;
      case (funct3_EXMEM[1:0])
         2'b00: begin
            be_s    = 4'b0001 << off_s;
            wdata_s = {4{rs2_data_EXMEM[7:0]}};
         end
         2'b01: begin
            be_s    = off_s[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{rs2_data_EXMEM[15:0]}};
         end
         2'b10: begin
            be_s    = 4'b1111;
            wdata_s = rs2_data_EXMEM;
         end
         default: begin
            be_s    = 4'b0000;
            wdata_s = rs2_data_EXMEM;
         end
      endcase
   end

   // Sequencing: stall holds everything, flush bubbles, a 2-cycle load
   // bubbles once in IDLE and is captured in WAIT.
   always_comb begin
      state_d   = state_q;
      busy_s    = 1'b0;
      capture_s = 1'b0;
      bubble_s  = 1'b0;
      we_s      = 1'b0;
      if (stall_in) begin
         state_d = state_q;
      end else if (flush_in) begin
         state_d  = ST_IDLE;
         bubble_s = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if ((READ_LAT == 2) && is_load_s) begin
                  state_d  = ST_WAIT;
                  busy_s   = 1'b1;
                  bubble_s = 1'b1;
               end else begin
                  capture_s = 1'b1;
                  we_s      = mem_wr_en_EXMEM & ~mis_s;
               end
            end
            ST_WAIT: begin
               state_d   = ST_IDLE;
               capture_s = 1'b1;
               we_s      = mem_wr_en_EXMEM & ~mis_s;
            end
            default: begin
               state_d  = ST_IDLE;
               bubble_s = 1'b1;
            end
         endcase
      end
   end

   // Busy is masked while reset is asserted so a held pipeline sees no request.
   assign mem_busy = busy_s & reset;

   // Next values of the RAM read pipeline and the MEM/WB register.
   always_comb begin
      rd1_d  = rd1_q;
      rd2_d  = rd2_q;
      alu_d  = alu_q;
      pc4_d  = pc4_q;
      ctrl_d = ctrl_q;
      rd_d   = rd_q;
      rwe_d  = rwe_q;
      mis_d  = mis_q;
      isld_d = isld_q;
      off_d  = off_q;
      f3_d   = f3_q;
      if (!stall_in) begin
         rd1_d = mem_q[word_idx_s];
         rd2_d = rd1_q;
      end else begin
         rd1_d = rd1_q;
         rd2_d = rd2_q;
      end
      if (capture_s) begin
         alu_d  = ALU_out_EXMEM;
         pc4_d  = pc_4_EXMEM;
         ctrl_d = reg_wr_ctrl_EXMEM;
         rd_d   = rd_EXMEM;
         rwe_d  = reg_wr_en_EXMEM & ~mis_s;
         mis_d  = mis_s;
         isld_d = is_load_s;
         off_d  = off_s;
         f3_d   = funct3_EXMEM;
      end else if (bubble_s) begin
         rwe_d  = 1'b0;
         mis_d  = 1'b0;
         isld_d = 1'b0;
      end else begin
         rwe_d  = rwe_q;
      end
   end

   // Memory array: byte-lane writes, contents are never reset.
   always_ff @(posedge clk) begin
      if (we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem_q[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
            end
         end
      end
   end

   // State, RAM output and MEM/WB registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         rd1_q   <= 32'd0;
         rd2_q   <= 32'd0;
         alu_q   <= 32'd0;
         pc4_q   <= 32'd0;
         ctrl_q  <= 2'd0;
         rd_q    <= 5'd0;
         rwe_q   <= 1'b0;
         mis_q   <= 1'b0;
         isld_q  <= 1'b0;
         off_q   <= 2'd0;
         f3_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         alu_q   <= alu_d;
         pc4_q   <= pc4_d;
         ctrl_q  <= ctrl_d;
         rd_q    <= rd_d;
         rwe_q   <= rwe_d;
         mis_q   <= mis_d;
         isld_q  <= isld_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
      end
   end

   assign ALU_out_MEMWB     = alu_q;
   assign pc_4_MEMWB        = pc4_q;
   assign reg_wr_ctrl_MEMWB = ctrl_q;
   assign rd_MEMWB          = rd_q;
   assign reg_wr_en_MEMWB   = rwe_q;
   assign misaligned_MEMWB  = mis_q;
   assign mem_rd_data_MEMWB = isld_q ?
                              load_extend((READ_LAT == 2) ? rd2_q : rd1_q, off_q, f3_q) :
                              32'd0;

endmodule
